bus_trace: RTL
==============

# bus_trace

Passive instruction-cycle tracer on the shared 4-bit system bus: it consumes the `sync`, `data`, `rom_cmd` and `ram_cmd_n` traffic driven by the CPU, ROMs and RAMs.
- Tracks the 8-phase machine cycle (A1 A2 A3 M1 M2 X1 X2 X3).
- Assembles one 32-bit record per completed cycle.
- Buffers records in a FIFO that a host drains over the wishbone backdoor.
- Never drives the data bus.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.

Ports:
- clock  in  1  system clock; one bus phase per clock.
- reset  in  1  synchronous, active-low reset.
- halt  in  1  high freezes phase counter and capture; wishbone stays live.
- sync  in  1  high for one clock during X3; next clock is A1.
- data_i  in  4  observed system data bus.
- rom_cmd  in  1  ROM command line.
- ram_cmd_n  in  4  RAM command lines, active-low.
- wb_data_i  in  32  host write data.
- wb_addr_i  in  32  byte address; only bits [3:2] decoded.
- wb_cyc_i, wb_strobe_i, wb_we_i  in  1 each  wishbone cycle, strobe and write enable.
- wb_data_o  out  32  read data; 0 when not acked; reset 0.
- wb_ack_o  out  1  one-clock acknowledge; reset 0.

## Operation
Phase tracker:
- States: UNLOCKED, A1, A2, A3, M1, M2, X1, X2, X3.
- Reset value: UNLOCKED.
- UNLOCKED to A1 on the clock after `sync`.
- Otherwise advances one state per clock, X3 to A1.
- `sync` seen in any state other than X3 forces A1 next and discards the partial record.
- `sync` absent in X3 returns the tracker to UNLOCKED; no record is pushed.

Capture, `data_i` sampled at the clock edge ending each phase:
- addr[3:0]: A1. addr[7:4]: A2. addr[11:8]: A3.
- opr: M1. opa: M2. xdat: X2.
- `rom_cmd` and `ram_cmd_n` are also sampled in X2.

Record format:
- [11:0] addr, [15:12] opa, [19:16] opr, [23:20] xdat.
- [27:24] ram_cmd_n, [28] rom_cmd, [31:29] seq.
- seq: 3-bit counter, +1 per pushed record, wraps 7 to 0, reset 0.

Push and FIFO:
- Push at the edge ending X3 when enable=1 and the tracker is locked.
- Full FIFO at push: record dropped; overflow sticky set; seq not incremented.
- Pop and push in the same clock on a full FIFO: the pop is applied first and the push is accepted.

Register map (word index = wb_addr_i[3:2]):
- 0 (R): FIFO head. Read pops the head. Empty read returns 0 and does not pop.
- 1 (R/W): status.
  - Read: [8:0] count, [9] overflow, [10] enable, [11] locked.
  - Write: bit0=1 clears overflow; bit1 sets enable; other bits ignored.
- 2: filter register (see Configuration).
- 3: reads 0; writes ignored.
- Reset values: enable=0, overflow=0, count=0.

## Timing
- Wishbone read or write is acknowledged exactly one clock after `wb_cyc_i & wb_strobe_i` is sampled high with `wb_ack_o` low.
- `wb_ack_o` is a single-clock pulse; back-to-back strobes are acked every other clock.
- Read data is valid in the ack cycle; the pop and register write take effect at the ack edge.
- A pushed record is readable from the clock after the edge ending X3.
- While `halt` is high the tracker, capture registers and seq hold; push cannot occur.
- Reset asserted mid-cycle returns the tracker to UNLOCKED and empties the FIFO on the next edge; any in-flight ack is dropped.

## Configuration
- TRACE_FILTER_EN defined:
  - Word 2 is a R/W address window: [11:0] lo, [27:16] hi.
  - Reset values: lo=0x000, hi=0xFFF.
  - Only records with lo ≤ addr ≤ hi are pushed; seq advances only on pushed records.
  - lo > hi pushes nothing.
- TRACE_FILTER_EN undefined:
  - Word 2 reads 0; writes are ignored.
  - Every completed cycle is pushed when enabled.

## Test plan
- Reset, enable, one cycle: `sync`, then A1..X3 data 3,2,1,D,4,0,7,0 with rom_cmd=1, ram_cmd_n=0xE in X2 → word 0 reads 0x1E7D4123 and status count=0.
- Mid-cycle `sync` in M1: the aborted cycle pushes nothing; the next full cycle pushes a record with seq=0.
- DEPTH+2 cycles with no reads → count=DEPTH, overflow=1, seq of the last stored record = (DEPTH-1) mod 8. Write status bit0=1 → overflow=0.
- Read of an empty FIFO → data 0, ack one clock after the strobe, count stays 0.
- `halt` high for 5 clocks during X1 → the record is identical to an unhalted run and is pushed 5 clocks later.
- TRACE_FILTER_EN with lo=0x100, hi=0x1FF; cycles at addr 0x0FF, 0x100, 0x200 → exactly one record (addr 0x100, seq 0).

Source files
------------

// File: rtl/bus_trace.sv
// bus_trace: passive tracer that turns each completed 8-phase bus cycle into a 32-bit record.
// Latency: a record is readable one clock after the edge ending X3; wishbone ack one clock after strobe.
// Backpressure: none on the bus side; records arriving at a full FIFO are dropped and flagged as overflow.
// Optional feature: define TRACE_FILTER_EN to enable the address-window filter on register word 2.

// Small first-word-fall-through FIFO; head is valid whenever o_empty is low.
module bus_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_dat,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_FULL);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  // A pop frees the slot the same clock, so a push into a full FIFO is accepted alongside it.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module bus_trace #(
  parameter int DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt,
  input  logic        sync,
  input  logic [3:0]  data_i,
  input  logic        rom_cmd,
  input  logic [3:0]  ram_cmd_n,
  input  logic [31:0] wb_data_i,
  input  logic [31:0] wb_addr_i,
  input  logic        wb_cyc_i,
  input  logic        wb_strobe_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    ST_UNLOCKED, ST_A1, ST_A2, ST_A3, ST_M1, ST_M2, ST_X1, ST_X2, ST_X3
  } state_t;

  state_t      r_state;
  logic [11:0] r_addr;
  logic [3:0]  r_opr;
  logic [3:0]  r_opa;
  logic [3:0]  r_xdat;
  logic        r_rom;
  logic [3:0]  r_ramn;
  logic [2:0]  r_seq;
  logic        r_enable;
  logic        r_ovf;
  logic        r_ack;
  logic [31:0] r_rdata;

  logic        w_locked;
  logic        w_cycle_done;
  logic        w_in_window;
  logic        w_push_req;
  logic        w_push_ok;
  logic [31:0] w_record;
  logic        w_wb_req;
  logic        w_wr;
  logic [1:0]  w_word;
  logic        w_pop;
  logic [31:0] w_head;
  logic [PW:0] w_count;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_rdata;
  logic [31:0] w_filt_word;
  logic        w_unused_bits;

  assign w_locked     = (r_state != ST_UNLOCKED);
  // A cycle completes only when sync arrives exactly in X3 and the tracker is not frozen.
  assign w_cycle_done = !halt && (r_state == ST_X3) && sync;
  assign w_record     = {r_seq, r_rom, r_ramn, r_xdat, r_opr, r_opa, r_addr};
  assign w_push_req   = w_cycle_done && r_enable && w_in_window;
  assign w_push_ok    = w_push_req && (!w_full || w_pop);

  assign w_wb_req     = wb_cyc_i && wb_strobe_i && !r_ack;
  assign w_wr         = w_wb_req && wb_we_i;
  assign w_word       = wb_addr_i[3:2];
  assign w_pop        = w_wb_req && !wb_we_i && (w_word == 2'd0) && !w_empty;

  assign wb_ack_o     = r_ack;
  assign wb_data_o    = r_rdata;
  assign w_unused_bits = ^{wb_addr_i, wb_data_i};

  // Phase tracker: sync anywhere resynchronises to A1; a missing sync in X3 drops lock.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_UNLOCKED;
    end else if (!halt) begin
      if (sync) begin
        r_state <= ST_A1;
      end else begin
        case (r_state)
          ST_A1:   r_state <= ST_A2;
          ST_A2:   r_state <= ST_A3;
          ST_A3:   r_state <= ST_M1;
          ST_M1:   r_state <= ST_M2;
          ST_M2:   r_state <= ST_X1;
          ST_X1:   r_state <= ST_X2;
          ST_X2:   r_state <= ST_X3;
          default: r_state <= ST_UNLOCKED;
        endcase
      end
    end
  end

  // Capture bus nibbles at the edge ending each phase; every field is rewritten each cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_addr <= '0;
      r_opr  <= '0;
      r_opa  <= '0;
      r_xdat <= '0;
      r_rom  <= 1'b0;
      r_ramn <= '0;
    end else if (!halt) begin
      case (r_state)
        ST_A1: r_addr[3:0]  <= data_i;
        ST_A2: r_addr[7:4]  <= data_i;
        ST_A3: r_addr[11:8] <= data_i;
        ST_M1: r_opr        <= data_i;
        ST_M2: r_opa        <= data_i;
        ST_X2: begin
          r_xdat <= data_i;
          r_rom  <= rom_cmd;
          r_ramn <= ram_cmd_n;
        end
        default: ;
      endcase
    end
  end

  // Sequence number advances only for records that actually land in the FIFO.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_seq <= '0;
    end else if (w_push_ok) begin
      r_seq <= r_seq + 3'd1;
    end
  end

  // Enable and sticky overflow; a drop in the same clock as a clear still leaves overflow set.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_enable <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr && (w_word == 2'd1)) begin
        r_enable <= wb_data_i[1];
        if (wb_data_i[0]) r_ovf <= 1'b0;
      end
      if (w_push_req && !w_push_ok) r_ovf <= 1'b1;
    end
  end

`ifdef TRACE_FILTER_EN
  logic [11:0] r_filt_lo;
  logic [11:0] r_filt_hi;

  // An inverted window (lo > hi) can never match, so it naturally suppresses every push.
  assign w_in_window = (r_addr >= r_filt_lo) && (r_addr <= r_filt_hi);
  assign w_filt_word = {4'd0, r_filt_hi, 4'd0, r_filt_lo};

  // Address window registers, writable through word 2.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_filt_lo <= 12'h000;
      r_filt_hi <= 12'hFFF;
    end else if (w_wr && (w_word == 2'd2)) begin
      r_filt_lo <= wb_data_i[11:0];
      r_filt_hi <= wb_data_i[27:16];
    end
  end
`else
  assign w_in_window = 1'b1;
  assign w_filt_word = 32'd0;
`endif

  bus_trace_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push_ok),
    .i_pop   (w_pop),
    .i_dat   (w_record),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Register read mux; an empty head reads as zero.
  always_comb begin
    w_rdata = 32'd0;
    case (w_word)
      2'd0:    w_rdata = w_empty ? 32'd0 : w_head;
      2'd1:    w_rdata = {20'd0, w_locked, r_enable, r_ovf, 9'(w_count)};
      2'd2:    w_rdata = w_filt_word;
      default: w_rdata = 32'd0;
    endcase
  end

  // Single-pulse ack; read data is latched with it and held at zero otherwise.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ack   <= w_wb_req;
      r_rdata <= (w_wb_req && !wb_we_i) ? w_rdata : 32'd0;
    end
  end
endmodule
